bram_port_server: RTL and testbench

- Request/response front-end that drives one port of the true dual-port byte-enable block RAM.
- Converts a valid/ready request stream (read or byte-masked write) into raw RAM port strobes.
- Captures read data one cycle later and returns it on a valid/ready response stream, buffered so back-pressure never loses data.
- Stalls reads that would collide with a same-cycle write on the peer RAM port; such a read would otherwise return X.

---
 rtl/bram_pkg.sv | 35 +++
 rtl/bram_port_server_if.sv | 31 +++
 rtl/bram_rsp_fifo.sv | 48 ++++
 rtl/bram_port_server.sv | 81 ++++++++
 tb/tb_bram_port_server.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bram_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bram_pkg: shared types and constants for the BRAM port server.       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package bram_pkg;

  localparam int ADDR_W_DEF     = 10;
  localparam int DATA_W_DEF     = 32;
  localparam int BE_W_DEF       = DATA_W_DEF / 8;
  localparam int RAM_RD_LATENCY = 1;

  typedef logic [ADDR_W_DEF-1:0] addr_t;
  typedef logic [DATA_W_DEF-1:0] data_t;
  typedef logic [BE_W_DEF-1:0]   be_t;

  typedef struct packed {
    logic  we;
    addr_t addr;
    data_t wdata;
    be_t   be;
  } bram_req_t;

  // Byte-lane merge as the RAM applies a masked write.
  function automatic data_t be_merge(data_t old_d, data_t new_d, be_t be);
    data_t r;
    r = old_d;
    for (int i = 0; i < BE_W_DEF; i++) begin
      if (be[i]) r[8*i +: 8] = new_d[8*i +: 8];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bram_port_server_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bram_port_server_if: request/response streams of the BRAM port server|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface bram_port_server_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [BE_WIDTH-1:0]   req_be;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface
`default_nettype wire

// File: rtl/bram_rsp_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bram_rsp_fifo: read-response buffer with registered head entry.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module bram_rsp_fifo #(
  parameter int DEPTH      = 2,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      push,
  input  logic [DATA_WIDTH-1:0]     push_data,
  input  logic                      pop,
  output logic [$clog2(DEPTH):0]    occ,
  output logic [DATA_WIDTH-1:0]     head
);
  localparam int PW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Storage needs no reset; occupancy alone decides validity.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule
`default_nettype wire

// File: rtl/bram_port_server.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bram_port_server: valid/ready front-end for one BRAM port.           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module bram_port_server
  import bram_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH / 8,
  parameter int RSP_DEPTH  = 2
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  bram_port_server_if.slave      bus,
  output logic [ADDR_WIDTH-1:0]  ram_addr,
  output logic [DATA_WIDTH-1:0]  ram_di,
  output logic                   ram_we,
  output logic                   ram_re,
  output logic [BE_WIDTH-1:0]    ram_be,
  input  logic [DATA_WIDTH-1:0]  ram_do,
  input  logic                   peer_we,
  input  logic [ADDR_WIDTH-1:0]  peer_addr
);
  localparam int OW = $clog2(RSP_DEPTH) + 1;
  localparam int CW = OW + 1;

  logic                      fire;
  logic                      collide;
  logic                      credit;
  logic                      push;
  logic                      pop;
  logic [OW-1:0]             occ;
  logic [CW-1:0]             pending;
  logic [RAM_RD_LATENCY-1:0] rd_pipe;

  // A read racing a peer write to the same word would return X from the RAM.
  assign collide = ~bus.req_we & peer_we & (peer_addr == bus.req_addr);

  // Every fired request, write or read, must find a free response slot.
  assign pending = CW'(occ) + CW'($countones(rd_pipe)) - CW'(pop);
  assign credit  = (pending < CW'(RSP_DEPTH));

  assign bus.req_ready = RST_N & credit & ~collide;
  assign fire          = bus.req_valid & bus.req_ready;

  assign ram_addr = bus.req_addr;
  assign ram_di   = bus.req_wdata;
  assign ram_be   = bus.req_be;
  assign ram_we   = fire & bus.req_we;
  assign ram_re   = fire & ~bus.req_we;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rd_pipe <= '0;
    end else begin
      rd_pipe[0] <= ram_re;
      for (int i = 1; i < RAM_RD_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end

  assign push          = rd_pipe[RAM_RD_LATENCY-1];
  assign pop           = bus.rsp_valid & bus.rsp_ready;
  assign bus.rsp_valid = (occ != '0);

  bram_rsp_fifo #(
    .DEPTH      (RSP_DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rsp_fifo (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .push      (push),
    .push_data (ram_do),
    .pop       (pop),
    .occ       (occ),
    .head      (bus.rsp_rdata)
  );

endmodule
`default_nettype wire

// File: tb/tb_bram_port_server.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_bram_port_server: directed and random checks of bram_port_server. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_bram_port_server;
  import bram_pkg::*;

  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int BW    = 4;
  localparam int DEPTH = 2;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_di;
  logic          ram_we;
  logic          ram_re;
  logic [BW-1:0] ram_be;
  logic [DW-1:0] ram_do = '0;
  logic          peer_we = 1'b0;
  logic [AW-1:0] peer_addr = '0;
  logic [DW-1:0] peer_data = '0;

  always #5 CLK = ~CLK;

  bram_port_server_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  bram_port_server #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .RSP_DEPTH  (DEPTH)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .bus       (bus),
    .ram_addr  (ram_addr),
    .ram_di    (ram_di),
    .ram_we    (ram_we),
    .ram_re    (ram_re),
    .ram_be    (ram_be),
    .ram_do    (ram_do),
    .peer_we   (peer_we),
    .peer_addr (peer_addr)
  );

  // Behavioural dual-port RAM; the peer port only writes.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge CLK) begin
    if (ram_re) ram_do <= mem[ram_addr];
    if (ram_we) mem[ram_addr] <= be_merge(mem[ram_addr], ram_di, ram_be);
    if (peer_we) mem[peer_addr] <= peer_data;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference memory and expected-response queue, built from observed requests.
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic [DW-1:0] exp_q [$];

  always @(negedge CLK) begin
    if (!RST_N) begin
      exp_q.delete();
    end else begin
      if (ram_we | ram_re) check("we_re_excl", 64'(ram_we & ram_re), 64'd0);
      if (bus.rsp_valid & bus.rsp_ready) begin
        if (exp_q.size() == 0) check("spurious_rsp", 64'd1, 64'd0);
        else check("rsp_data", 64'(bus.rsp_rdata), 64'(exp_q.pop_front()));
      end
      if (bus.req_valid & bus.req_ready) begin
        if (!bus.req_we) begin
          exp_q.push_back(ref_mem[bus.req_addr]);
          check("no_overflow", 64'(exp_q.size() <= DEPTH), 64'd1);
        end else begin
          ref_mem[bus.req_addr] = be_merge(ref_mem[bus.req_addr], bus.req_wdata, bus.req_be);
        end
      end
      if (peer_we) ref_mem[peer_addr] = peer_data;
    end
  end

  task automatic set_req(input bram_req_t r);
    bus.req_we    = r.we;
    bus.req_addr  = r.addr;
    bus.req_wdata = r.wdata;
    bus.req_be    = r.be;
  endtask

  // Entered and left at posedge+1; request fires on the edge after req_ready is seen.
  task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [BW-1:0] be);
    int waited;
    waited = 0;
    set_req('{we: we, addr: a, wdata: d, be: be});
    bus.req_valid = 1'b1;
    @(negedge CLK);
    while (!bus.req_ready && waited < 50) begin
      waited++;
      @(negedge CLK);
    end
    if (!bus.req_ready) check("req_timeout", 64'd0, 64'd1);
    @(posedge CLK); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output logic [DW-1:0] d);
    int waited;
    waited = 0;
    d = '0;
    @(negedge CLK);
    while (!(bus.rsp_valid && bus.rsp_ready) && waited < 50) begin
      waited++;
      @(negedge CLK);
    end
    if (!(bus.rsp_valid && bus.rsp_ready)) check("rsp_timeout", 64'd0, 64'd1);
    else d = bus.rsp_rdata;
    @(posedge CLK); #1;
  endtask

  logic [DW-1:0] rd;
  int            idx;
  int            stale;
  logic          fired;

  initial begin
    bus.req_valid = 1'b1;
    set_req('{we: 1'b0, addr: 10'h0, wdata: 32'h0, be: 4'h0});
    bus.rsp_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check("rst_ram_re", 64'(ram_re), 64'd0);
    check("rst_ram_we", 64'(ram_we), 64'd0);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge CLK); #1;

    // Full write then read-back, with exact latency
    set_req('{we: 1'b1, addr: 10'h005, wdata: 32'hDEADBEEF, be: 4'hF});
    bus.req_valid = 1'b1;
    @(negedge CLK);
    check("t1_wr_ready", 64'(bus.req_ready), 64'd1);
    check("t1_ram_we", 64'(ram_we), 64'd1);
    check("t1_ram_re_wr", 64'(ram_re), 64'd0);
    @(posedge CLK); #1;
    bus.req_valid = 1'b0;
    @(negedge CLK);
    check("t1_we_pulse", 64'(ram_we), 64'd0);
    @(posedge CLK); #1;
    set_req('{we: 1'b0, addr: 10'h005, wdata: 32'h0, be: 4'h0});
    bus.req_valid = 1'b1;
    @(negedge CLK);
    check("t1_rd_ready", 64'(bus.req_ready), 64'd1);
    check("t1_ram_re", 64'(ram_re), 64'd1);
    @(posedge CLK); #1;
    bus.req_valid = 1'b0;
    @(negedge CLK);
    check("t1_lat_n1", 64'(bus.rsp_valid), 64'd0);
    @(negedge CLK);
    check("t1_lat_n2", 64'(bus.rsp_valid), 64'd1);
    check("t1_rdata", 64'(bus.rsp_rdata), 64'hDEADBEEF);
    @(posedge CLK); #1;

    // Byte-masked write
    issue(1'b1, 10'h010, 32'h11223344, 4'hF);
    issue(1'b1, 10'h010, 32'hAABBCCDD, 4'b0101);
    issue(1'b0, 10'h010, 32'h0, 4'h0);
    wait_rsp(rd);
    check("t2_be_merge", 64'(rd), 64'h11BB33DD);

    // Preload for later tests
    for (int i = 0; i < 8; i++) issue(1'b1, AW'(10'h040 + i), 32'hA0000000 + i, 4'hF);
    for (int i = 0; i < 16; i++) issue(1'b1, AW'(10'h080 + i), $urandom, 4'hF);
    issue(1'b1, 10'h020, 32'hCAFEF00D, 4'hF);
    repeat (2) @(posedge CLK);
    #1;

    // Back-to-back reads at full rate
    for (int i = 0; i < 10; i++) begin
      bus.req_valid = (i < 8);
      set_req('{we: 1'b0, addr: AW'(10'h040 + i), wdata: 32'h0, be: 4'h0});
      @(negedge CLK);
      if (i < 8) check("t3_ready", 64'(bus.req_ready), 64'd1);
      if (i >= 2) begin
        check("t3_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        check("t3_rsp_order", 64'(bus.rsp_rdata), 64'(32'hA0000000 + (i - 2)));
      end
      @(posedge CLK); #1;
    end
    bus.req_valid = 1'b0;

    // Back-pressure: two reads accepted, then stall with head held
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      set_req('{we: 1'b0, addr: AW'(10'h040 + idx), wdata: 32'h0, be: 4'h0});
      @(negedge CLK);
      check("t3_bp_ready", 64'(bus.req_ready), 64'(c < 2));
      if (c >= 2) begin
        check("t3_bp_valid", 64'(bus.rsp_valid), 64'd1);
        check("t3_bp_hold", 64'(bus.rsp_rdata), 64'hA0000000);
      end
      fired = bus.req_ready;
      @(posedge CLK); #1;
      if (fired) idx++;
    end
    check("t3_bp_accepted", 64'(idx), 64'd2);
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    wait_rsp(rd);
    check("t3_bp_rsp0", 64'(rd), 64'hA0000000);
    wait_rsp(rd);
    check("t3_bp_rsp1", 64'(rd), 64'hA0000001);

    // Peer collision stalls a read but not a write
    peer_we = 1'b1;
    peer_addr = 10'h031;
    peer_data = 32'h00000066;
    set_req('{we: 1'b1, addr: 10'h031, wdata: 32'h00000055, be: 4'hF});
    bus.req_valid = 1'b1;
    @(negedge CLK);
    check("t4_wr_no_stall", 64'(bus.req_ready), 64'd1);
    @(posedge CLK); #1;
    peer_addr = 10'h020;
    peer_data = 32'h12345678;
    set_req('{we: 1'b0, addr: 10'h020, wdata: 32'h0, be: 4'h0});
    @(negedge CLK);
    check("t4_collide_ready", 64'(bus.req_ready), 64'd0);
    check("t4_collide_re", 64'(ram_re), 64'd0);
    @(posedge CLK); #1;
    peer_we = 1'b0;
    @(negedge CLK);
    check("t4_after_ready", 64'(bus.req_ready), 64'd1);
    @(posedge CLK); #1;
    bus.req_valid = 1'b0;
    wait_rsp(rd);
    check("t4_rdata", 64'(rd), 64'h12345678);

    // Reset while a read is in flight
    bus.rsp_ready = 1'b0;
    issue(1'b0, 10'h020, 32'h0, 4'h0);
    RST_N = 1'b0;
    bus.req_valid = 1'b1;
    @(negedge CLK);
    check("t5_rst_ready", 64'(bus.req_ready), 64'd0);
    check("t5_rst_re", 64'(ram_re), 64'd0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge CLK);
    check("t5_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    stale = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      if (bus.rsp_valid) stale++;
    end
    check("t5_no_stale", 64'(stale), 64'd0);
    @(posedge CLK); #1;

    // Random mixed traffic against the reference model
    for (int c = 0; c < 400; c++) begin
      if (!bus.req_valid && $urandom_range(0, 9) < 7) begin
        set_req('{we: 1'($urandom_range(0, 1)), addr: AW'(10'h080 + $urandom_range(0, 15)),
                  wdata: $urandom, be: BW'($urandom_range(0, 15))});
        bus.req_valid = 1'b1;
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      peer_we   = ($urandom_range(0, 3) == 0);
      peer_addr = AW'(10'h080 + $urandom_range(0, 15));
      peer_data = $urandom;
      if (bus.req_valid && bus.req_we && peer_addr == bus.req_addr) peer_we = 1'b0;
      @(negedge CLK);
      fired = bus.req_valid & bus.req_ready;
      @(posedge CLK); #1;
      if (fired) bus.req_valid = 1'b0;
    end
    bus.req_valid = 1'b0;
    peer_we = 1'b0;
    bus.rsp_ready = 1'b1;
    repeat (10) @(posedge CLK);
    #1;
    check("t6_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
